// File: rtl/smi_rx_arbiter_if.sv
// Bus bundle between the RX arbiter, its two source FIFOs and the SMI controller RX port.
interface smi_rx_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic [1:0]        i_mode;
    logic              i_ch_sel;
    logic              i_ch0_empty;
    logic              i_ch1_empty;
    logic              o_ch0_pull;
    logic              o_ch1_pull;
    logic [DATA_W-1:0] i_ch0_data;
    logic [DATA_W-1:0] i_ch1_data;
    logic              i_pull;
    logic [DATA_W-1:0] o_data;
    logic              o_empty;
    logic              o_cur_ch;
    logic [CNT_W-1:0]  o_drop_cnt;

    modport slave (
        input  i_mode, i_ch_sel, i_ch0_empty, i_ch1_empty, i_ch0_data, i_ch1_data, i_pull,
        output o_ch0_pull, o_ch1_pull, o_data, o_empty, o_cur_ch, o_drop_cnt
    );

    modport master (
        output i_mode, i_ch_sel, i_ch0_empty, i_ch1_empty, i_ch0_data, i_ch1_data, i_pull,
        input  o_ch0_pull, o_ch1_pull, o_data, o_empty, o_cur_ch, o_drop_cnt
    );
endinterface

// File: rtl/smi_rx_arbiter.sv
// Two-channel RX FIFO arbiter feeding a one-word buffer read by the SMI controller.
// Fixed-channel or round-robin selection; one word per 3 cycles at best.
module smi_rx_arbiter #(
    parameter bit G_TAG_EN = 1'b1
) (
    input  logic            i_sys_clk,
    input  logic            i_rst_b,
    smi_rx_arbiter_if.slave bus
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 8;
    localparam logic [1:0]  MODE_FIXED = 2'b01;
    localparam logic [1:0]  MODE_RR    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic              armed_q,    armed_d;
    logic              empty_q,    empty_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              cur_ch_q,   cur_ch_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              pull0_q,    pull0_d;
    logic              pull1_q,    pull1_d;
    logic              last_ch_q,  last_ch_d;
    logic              fetch_ch_q, fetch_ch_d;
    logic              fetch_tag_q, fetch_tag_d;

    logic              sel_ch;
    logic              sel_avail;
    logic              rr_pref;
    logic              rr_pref_empty;

    // Next-state, selection and buffer update
    always_comb begin
        state_d       = state_q;
        armed_d       = 1'b1;
        empty_d       = empty_q;
        data_d        = data_q;
        cur_ch_d      = cur_ch_q;
        drop_cnt_d    = drop_cnt_q;
        pull0_d       = 1'b0;
        pull1_d       = 1'b0;
        last_ch_d     = last_ch_q;
        fetch_ch_d    = fetch_ch_q;
        fetch_tag_d   = fetch_tag_q;
        sel_ch        = 1'b0;
        sel_avail     = 1'b0;
        rr_pref       = ~last_ch_q;
        rr_pref_empty = rr_pref ? bus.i_ch1_empty : bus.i_ch0_empty;

        case (bus.i_mode)
            MODE_FIXED: begin
                sel_ch    = bus.i_ch_sel;
                sel_avail = bus.i_ch_sel ? ~bus.i_ch1_empty : ~bus.i_ch0_empty;
            end
            MODE_RR: begin
                sel_ch    = rr_pref_empty ? ~rr_pref : rr_pref;
                sel_avail = ~(bus.i_ch0_empty & bus.i_ch1_empty);
            end
            default: ;
        endcase

        // A pull on an empty buffer only bumps the saturating drop counter
        if (bus.i_pull) begin
            if (!empty_q) begin
                empty_d = 1'b1;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && sel_avail && (empty_q || bus.i_pull)) begin
                    state_d     = ST_FETCH;
                    pull0_d     = ~sel_ch;
                    pull1_d     = sel_ch;
                    fetch_ch_d  = sel_ch;
                    fetch_tag_d = G_TAG_EN && (bus.i_mode == MODE_RR);
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_d    = fetch_ch_q ? bus.i_ch1_data : bus.i_ch0_data;
                if (fetch_tag_q) begin
                    data_d[0] = fetch_ch_q;
                end
                empty_d   = 1'b0;
                cur_ch_d  = fetch_ch_q;
                last_ch_d = fetch_ch_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and buffer registers; armed_q delays the first pull past the first edge after reset
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            empty_q     <= 1'b1;
            data_q      <= '0;
            cur_ch_q    <= 1'b0;
            drop_cnt_q  <= '0;
            pull0_q     <= 1'b0;
            pull1_q     <= 1'b0;
            last_ch_q   <= 1'b1;
            fetch_ch_q  <= 1'b0;
            fetch_tag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            empty_q     <= empty_d;
            data_q      <= data_d;
            cur_ch_q    <= cur_ch_d;
            drop_cnt_q  <= drop_cnt_d;
            pull0_q     <= pull0_d;
            pull1_q     <= pull1_d;
            last_ch_q   <= last_ch_d;
            fetch_ch_q  <= fetch_ch_d;
            fetch_tag_q <= fetch_tag_d;
        end
    end

    assign bus.o_ch0_pull = pull0_q;
    assign bus.o_ch1_pull = pull1_q;
    assign bus.o_data     = data_q;
    assign bus.o_empty    = empty_q;
    assign bus.o_cur_ch   = cur_ch_q;
    assign bus.o_drop_cnt = drop_cnt_q;
endmodule
